// File: rtl/ps2_ascii_fifo_pkg.sv
// Scan-code constants, repeat-state encoding and the make-code to ASCII translation
// shared by the keyboard character path.
package ps2_keys_pkg;

  localparam logic [8:0] KEY_LSHIFT = 9'h012;
  localparam logic [8:0] KEY_RSHIFT = 9'h059;
  localparam logic [8:0] KEY_CAPS   = 9'h058;
  localparam logic [8:0] KEY_SPACE  = 9'h029;
  localparam logic [8:0] KEY_ENTER  = 9'h05A;
  localparam logic [8:0] KEY_BKSP   = 9'h066;

  // Indexed by alphabet position / digit value so translation is plain arithmetic
  localparam logic [8:0] LETTER_CODES [26] = '{
    9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033, 9'h043,
    9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044, 9'h04D, 9'h015, 9'h02D,
    9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D, 9'h022, 9'h035, 9'h01A};
  localparam logic [8:0] DIGIT_CODES [10] = '{
    9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
  localparam logic [8:0] KEYPAD_CODES [10] = '{
    9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};
  localparam logic [7:0] SHIFT_DIGIT_CHARS [10] = '{
    8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
  } xlat_t;

  function automatic xlat_t translate(input logic [8:0] code, input logic shift,
                                      input logic caps);
    xlat_t r;
    r.valid = 1'b0;
    r.ch    = 8'h00;
    for (int i = 0; i < 26; i++) begin
      if (code == LETTER_CODES[i]) begin
        r.valid = 1'b1;
        r.ch    = ((shift ^ caps) ? 8'h41 : 8'h61) + 8'(i);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (code == DIGIT_CODES[i]) begin
        r.valid = 1'b1;
        r.ch    = shift ? SHIFT_DIGIT_CHARS[i] : 8'h30 + 8'(i);
      end
      if (code == KEYPAD_CODES[i]) begin
        r.valid = 1'b1;
        r.ch    = 8'h30 + 8'(i);
      end
    end
    if (code == KEY_SPACE) begin
      r.valid = 1'b1;
      r.ch    = 8'h20;
    end
    if (code == KEY_ENTER) begin
      r.valid = 1'b1;
      r.ch    = 8'h0D;
    end
    if (code == KEY_BKSP) begin
      r.valid = 1'b1;
      r.ch    = 8'h08;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_ascii_fifo_if.sv
// Character pop port: the producer drives head data/valid/occupancy, the consumer drives ready.
interface ps2_ascii_fifo_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    char_data;
  logic          char_valid;
  logic          char_ready;
  logic [CW-1:0] count;

  modport master (output char_data, output char_valid, output count, input char_ready);
  modport slave  (input char_data, input char_valid, input count, output char_ready);
endinterface

// File: rtl/ps2_ascii_fifo_fifo.sv
// Power-of-two character FIFO; a push into a full FIFO is accepted only alongside a pop.
module ps2_char_fifo #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_fifo.sv
// Turns KeyboardDecoder make events into ASCII (Shift, Caps Lock, typematic repeat)
// and queues them for a valid/ready consumer.
module ps2_ascii_fifo
  import ps2_keys_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter bit          CAPS_EN      = 1'b1,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      key_down,
  input  logic [8:0]        last_change,
  input  logic              key_valid,
  ps2_ascii_fifo_if.master  char_port,
  output logic              caps_lock,
  output logic              overflow
);

  localparam int CW = $clog2(DEPTH + 1);

  rpt_state_t    state, next_state;
  logic [8:0]    held_code, next_held;
  logic [31:0]   cnt, next_cnt;
  logic [31:0]   period_last;
  logic          shift, make_evt, mapped_make, rpt_fire;
  logic          push, fifo_full, fifo_empty;
  logic [7:0]    push_data, pop_data;
  logic [CW-1:0] fifo_count;
  xlat_t         evt_xlat, rpt_xlat;

  assign shift       = key_down[KEY_LSHIFT] | key_down[KEY_RSHIFT];
  assign make_evt    = key_valid && key_down[last_change];
  assign evt_xlat    = translate(last_change, shift, caps_lock);
  assign rpt_xlat    = translate(held_code, shift, caps_lock);
  assign mapped_make = make_evt && evt_xlat.valid;
  assign period_last = (state == RPT_DELAY) ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RPT_IDLE;
      held_code <= '0;
      cnt       <= '0;
    end else begin
      state     <= next_state;
      held_code <= next_held;
      cnt       <= next_cnt;
    end
  end

  // A new mapped make always restarts the delay; unmapped makes leave the FSM alone
  always_comb begin
    next_state = state;
    next_held  = held_code;
    next_cnt   = cnt;
    if (REPEAT_EN && mapped_make) begin
      next_state = RPT_DELAY;
      next_held  = last_change;
      next_cnt   = '0;
    end else if (REPEAT_EN) begin
      case (state)
        RPT_DELAY, RPT_REPEAT: begin
          if (!key_down[held_code]) begin
            next_state = RPT_IDLE;
            next_cnt   = '0;
          end else if (cnt == period_last) begin
            next_state = RPT_REPEAT;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
        default: next_state = RPT_IDLE;
      endcase
    end
  end

  always_comb begin
    rpt_fire = 1'b0;
    if (state != RPT_IDLE && !mapped_make && key_down[held_code] && cnt == period_last)
      rpt_fire = rpt_xlat.valid;
  end

  assign push      = mapped_make || rpt_fire;
  assign push_data = mapped_make ? evt_xlat.ch : rpt_xlat.ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      caps_lock <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (CAPS_EN && make_evt && last_change == KEY_CAPS) caps_lock <= ~caps_lock;
      if (push && fifo_full && !char_port.char_ready) overflow <= 1'b1;
    end
  end

  ps2_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (char_port.char_ready),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign char_port.char_data  = pop_data;
  assign char_port.char_valid = !fifo_empty;
  assign char_port.count      = fifo_count;

endmodule
